// File: rtl/stallmem_param.sv
// stallmem_param: latching multi-cycle stalling byte memory, optional LFSR extra delay via STALLMEM_RAND_STALL_EN
module stallmem_param #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int LATENCY = 2,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] DataIn,
  input  logic              Rd,
  input  logic              Wr,
  output logic [DATA_W-1:0] DataOut,
  output logic              Done,
  output logic              Stall,
  output logic              err
);
  localparam int NB = DATA_W / 8;
  localparam int CW = $clog2(LATENCY + 4);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state;
  logic [7:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q, rd_word;
  logic op_wr;
  logic [CW-1:0] cnt;
  logic [1:0] x;
  logic misaligned, valid, commit;
  assign misaligned = (Addr % ADDR_W'(NB)) != '0;
  assign valid = (Rd ^ Wr) & ~misaligned;
  assign commit = state == WAIT && cnt == '0;
  assign Stall = ~rst & ((state == IDLE & valid) | state == WAIT);
  assign err = ~rst & state == IDLE & (Rd | Wr) & (misaligned | (Rd & Wr));
  assign Done = state == DONE;
`ifdef STALLMEM_RAND_STALL_EN
  logic [15:0] lfsr;
  assign x = lfsr[1:0];
  // advance the Galois LFSR once per accepted request
  always_ff @(posedge clk)
    if (rst) lfsr <= LFSR_SEED;
    else if (state == IDLE && valid) lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
`else
  assign x = 2'b00;
`endif
  // big-endian word gather from the latched address
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NB; i++) rd_word[DATA_W-1-8*i -: 8] = mem[addr_q + ADDR_W'(i)];
  end
  // commit all bytes of a write on the edge into DONE; contents survive reset
  always_ff @(posedge clk)
    if (!rst && commit && op_wr)
      for (int i = 0; i < NB; i++) mem[addr_q + ADDR_W'(i)] <= data_q[DATA_W-1-8*i -: 8];
  // request FSM: accept, count down the wait, then present one Done cycle
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      DataOut <= '0;
      op_wr <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else case (state)
      IDLE: if (valid) begin
        state <= WAIT;
        op_wr <= Wr;
        addr_q <= Addr;
        data_q <= DataIn;
        cnt <= CW'(LATENCY - 1) + CW'(x);
      end
      WAIT: begin
        state <= cnt == '0 ? DONE : WAIT;
        cnt <= cnt == '0 ? cnt : cnt - 1'b1;
        DataOut <= commit && !op_wr ? rd_word : '0;
      end
      default: begin
        state <= IDLE;
        DataOut <= '0;
      end
    endcase
endmodule

// File: tb/tb_stallmem_param.sv
// tb_stallmem_param: scoreboard bench for stallmem_param with a word-level reference memory
module tb_stallmem_param;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int LAT = 2;
  logic clk = 0, rst = 1, rd = 0, wr = 0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] DataOut;
  logic Done, Stall, err;
  stallmem_param #(.DATA_W(DW), .ADDR_W(AW), .LATENCY(LAT), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .Addr(addr), .DataIn(din), .Rd(rd), .Wr(wr),
    .DataOut(DataOut), .Done(Done), .Stall(Stall), .err(err));
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int errors = 0, checks = 0;
  typedef struct {logic [DW-1:0] data; int t0; int lat;} exp_t;
  exp_t q[$];
  exp_t me;
  logic [DW-1:0] mem_m [int];
  logic [15:0] lfsr_m = 16'hACE1;
  bit mon_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int xnext();
`ifdef STALLMEM_RAND_STALL_EN
    int x = int'(lfsr_m[1:0]);
    lfsr_m = {1'b0, lfsr_m[15:1]} ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
    return x;
`else
    return 0;
`endif
  endfunction

  function automatic logic [DW-1:0] rdm(input logic [AW-1:0] a);
    return mem_m.exists(int'(a)) ? mem_m[int'(a)] : '0;
  endfunction

  always begin
    @(negedge clk);
    #4;
    if (mon_en && !rst) begin
      if (Done) begin
        if (q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          me = q.pop_front();
          chk("data", DataOut, me.data);
          chk("latency", cyc - me.t0, me.lat);
          chk("stall_at_done", Stall, 0);
        end
      end else begin
        chk("dataout_idle", DataOut, 0);
        if (q.size() > 0) chk("stall_busy", Stall, 1);
      end
    end
  end

  task automatic req(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit ok = (r ^ w) && a[0] == 1'b0;
    bit e = (r | w) && !ok;
    exp_t it;
    @(negedge clk);
    rd = r; wr = w; addr = a; din = d;
    #2;
    chk("err", err, e);
    chk("stall_accept", Stall, ok);
    if (ok) begin
      it.t0 = cyc;
      it.lat = LAT + 1 + xnext();
      it.data = r ? rdm(a) : '0;
      if (w) mem_m[int'(a)] = d;
      q.push_back(it);
    end
    @(posedge clk);
    #1;
    rd = 0; wr = 0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 30; i++) begin
      if (q.size() == 0) return;
      @(negedge clk);
      #5;
    end
    if (q.size() != 0) begin
      chk("timeout", 1, 0);
      q.delete();
    end
  endtask

  initial begin
    rd = 1;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_stall", Stall, 0);
    chk("rst_err", err, 0);
    chk("rst_done", Done, 0);
    chk("rst_dataout", DataOut, 0);
    rd = 0;
    @(negedge clk);
    rst = 0;
    mon_en = 1;
    req(0, 1, 16'h0010, 16'hBEEF); wait_idle();
    req(1, 0, 16'h0010, 16'h0000); wait_idle();
    req(1, 0, 16'h0011, 16'h0000); wait_idle();
    req(1, 1, 16'h0020, 16'h1111); wait_idle();
    req(1, 0, 16'h0020, 16'h0000); wait_idle();
    req(0, 1, 16'h0040, 16'hAAAA);
    @(negedge clk);
    wr = 1; addr = 16'h0042; din = 16'h5555;
    #2;
    chk("err_in_wait", err, 0);
    chk("stall_in_wait", Stall, 1);
    @(posedge clk);
    #1;
    wr = 0;
    wait_idle();
    req(1, 0, 16'h0042, 16'h0000); wait_idle();
    req(1, 0, 16'h0040, 16'h0000); wait_idle();
    req(0, 1, 16'h0030, 16'h1234);
    @(negedge clk);
    rst = 1;
    #2;
    chk("stall_mid_rst", Stall, 0);
    chk("err_mid_rst", err, 0);
    q.delete();
    mem_m.delete(32'h30);
    lfsr_m = 16'hACE1;
    @(negedge clk);
    rst = 0;
    repeat (6) @(negedge clk);
    req(1, 0, 16'h0030, 16'h0000); wait_idle();
    for (int n = 0; n < 40; n++) begin
      logic [AW-1:0] a = 16'h0100 + AW'($urandom_range(0, 15) * 2) + AW'($urandom_range(0, 7) == 0);
      int op = $urandom_range(0, 9);
      req(op < 4 || op > 7, op >= 4, a, DW'($urandom));
      wait_idle();
    end
`ifdef STALLMEM_RAND_STALL_EN
    for (int n = 0; n < 16; n++) begin
      req(1, 0, 16'h0100 + AW'(n * 2), '0);
      wait_idle();
    end
`endif
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/stallmem_param.md
# stallmem_param

Parametrised, latching, multi-cycle stalling memory model for the processor's memory stage and for cache backing store. It captures a request in one cycle and completes it after a configurable wait. An optional pseudo-random extra delay exercises the stall path. Data width, address width and base latency are generic. It replaces the single-cycle fixed-width stalling memory for cache-miss and variable-latency testing.

## Interface
Parameters:
- DATA_W, 16, word width in bits; a multiple of 8 and at least 16.
- ADDR_W, 16, byte-address width; the memory holds 2^ADDR_W bytes.
- LATENCY, 2, base wait cycles; at least 1.
- LFSR_SEED, 16'hACE1, reset value of the delay LFSR; must be nonzero.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- Addr  in  ADDR_W  byte address; must be aligned to DATA_W/8
- DataIn  in  DATA_W  write data
- Rd  in  1  read request
- Wr  in  1  write request
- DataOut  out  DATA_W  read data; valid only while Done=1, otherwise 0
- Done  out  1  one-cycle completion pulse
- Stall  out  1  request accepted or in progress, not yet complete
- err  out  1  request rejected: misaligned address, or Rd and Wr both high

## Operation
- Byte storage is big-endian: the byte at Addr is DataOut[DATA_W-1:DATA_W-8].
- Reset does not change memory contents.
- The state machine has three states: IDLE, WAIT and DONE.
- In IDLE:
  - A request is valid when (Rd^Wr)=1 and Addr is aligned.
  - On a valid request, the block latches the op, Addr and DataIn, loads wait counter = LATENCY+X−1, and moves to WAIT.
  - Stall=1 in the accept cycle.
  - err = (Rd|Wr) & (misaligned | (Rd&Wr)), combinational, in IDLE only.
  - An errored request is dropped: the block stays in IDLE, with no access, no Done and Stall=0.
- In WAIT:
  - Stall=1.
  - The counter decrements each cycle; at 0 the block moves to DONE.
  - Rd, Wr, Addr and DataIn are ignored, so requests presented while busy are dropped.
- DONE transition:
  - On the edge into DONE, a write commits all DATA_W/8 bytes.
  - On the same edge, a read registers DataOut from memory. A read issued directly after a write returns the new data.
- In DONE: Done=1, Stall=0, err=0, inputs are ignored, and the next state is IDLE.
- X is the extra delay: 0 without the macro, or the LFSR low 2 bits at acceptance with the macro (see Configuration).

## Timing
- Reset values: state IDLE, Done=0, DataOut=0, LFSR=LFSR_SEED, counter=0. Stall=0 and err=0 while rst=1.
- For a request accepted in cycle T:
  - Stall is high in cycles T through T+LATENCY+X.
  - Done is high in cycle T+LATENCY+X+1.
  - With LATENCY=2 and X=0, Done is at T+3.
- Minimum request spacing is LATENCY+2 cycles; a new request may be accepted in the cycle after Done.
- Reset mid-operation aborts the access: a pending write is discarded, and Done never fires for it.
- Address arithmetic is modulo 2^ADDR_W. Aligned accesses never wrap within a word.

## Configuration
- Macro: STALLMEM_RAND_STALL_EN.
- Defined:
  - A 16-bit Galois LFSR with taps x^16+x^14+x^13+x^11+1 supplies X = LFSR[1:0], range 0..3.
  - The LFSR advances exactly once per accepted (non-err) request and is reset to LFSR_SEED.
  - Total latency is therefore LATENCY+1 to LATENCY+4 cycles.
- Undefined: X=0, no LFSR logic is present, and latency is always LATENCY+1.

## Test plan
All scenarios use DATA_W=16, ADDR_W=16 and LATENCY=2, with the macro undefined unless stated.
- Wr 16'hBEEF @0x0010 in cycle T → Stall=1 in T..T+2, Done at T+3; then Rd @0x0010 → DataOut=16'hBEEF with Done at +3, and DataOut=0 in all other cycles.
- Rd @0x0011 → err=1 in the same cycle, Stall=0, no Done, state stays IDLE.
- Rd=Wr=1 @0x0020 with DataIn=16'h1111 → err=1; a later read of 0x0020 returns 16'h0000.
- Wr 16'hAAAA @0x0040, then Wr 16'h5555 @0x0042 presented during WAIT → only 0x0040 is written; reading 0x0042 returns 16'h0000.
- Wr 16'h1234 @0x0030 with rst pulsed at T+1 → no Done; a read of 0x0030 after reset returns 16'h0000.
- STALLMEM_RAND_STALL_EN defined, 16 back-to-back reads → every Done latency is in 3..6 and matches a reference LFSR model seeded with 16'hACE1.
